// File: rtl/ialu_req_arb.sv
// Two-requester round-robin arbiter and sequencer in front of the shared SCR1 IALU.
// A granted operation runs single-cycle or RVM (timeout-guarded) and is answered on one response channel.
module ialu_req_arb #(
  parameter int SCR1_XLEN           = 8,
  parameter int SCR1_IALU_CMD_WIDTH = 8,
  parameter int RVM_CMD_BIT         = SCR1_IALU_CMD_WIDTH - 1,
  parameter int MDU_TIMEOUT         = 64
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic [1:0]                       req_vd_i,
  output logic [1:0]                       req_rdy_o,
  input  logic [2*SCR1_XLEN-1:0]           req_op1_i,
  input  logic [2*SCR1_XLEN-1:0]           req_op2_i,
  input  logic [2*SCR1_IALU_CMD_WIDTH-1:0] req_cmd_i,
  output logic [SCR1_XLEN-1:0]             ialu_main_op1_o,
  output logic [SCR1_XLEN-1:0]             ialu_main_op2_o,
  output logic [SCR1_IALU_CMD_WIDTH-1:0]   ialu_cmd_o,
  output logic                             ialu_rvm_cmd_vd_o,
  input  logic [SCR1_XLEN-1:0]             ialu_main_res_i,
  input  logic                             ialu_cmp_res_i,
  input  logic                             ialu_rvm_res_rdy_i,
  output logic                             rsp_vd_o,
  input  logic                             rsp_rdy_i,
  output logic                             rsp_id_o,
  output logic [SCR1_XLEN-1:0]             rsp_res_o,
  output logic                             rsp_cmp_o,
  output logic                             rsp_err_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(MDU_TIMEOUT - 1);

  state_t                           state_q, state_d;
  logic                             last_q;
  logic [7:0]                       cnt_q;
  logic [SCR1_XLEN-1:0]             op1_q, op2_q, res_q;
  logic [SCR1_IALU_CMD_WIDTH-1:0]   cmd_q;
  logic                             id_q, cmp_q, err_q, rvm_vd_q;

  logic                             any_req, gnt_id, accept;
  logic                             is_rvm, exec_ok, exec_done;

  // Both requesting: the one that did not win last time goes first.
  assign any_req = |req_vd_i;
  assign gnt_id  = (req_vd_i == 2'b11) ? ~last_q : req_vd_i[1];
  assign accept  = (state_q == IDLE) && any_req;

  assign is_rvm    = cmd_q[RVM_CMD_BIT];
  assign exec_ok   = !is_rvm || ialu_rvm_res_rdy_i;
  assign exec_done = exec_ok || (cnt_q == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req)   state_d = EXEC;
      EXEC:    if (exec_done) state_d = RESP;
      RESP:    if (rsp_rdy_i) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Reset gates the combinational accept so nothing is granted while held in reset.
  always_comb begin
    req_rdy_o = 2'b00;
    rsp_vd_o  = 1'b0;
    if (accept && rst_n_i) req_rdy_o = gnt_id ? 2'b10 : 2'b01;
    if (state_q == RESP)   rsp_vd_o  = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_q   <= 1'b1;
      cnt_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      cmd_q    <= '0;
      id_q     <= 1'b0;
      res_q    <= '0;
      cmp_q    <= 1'b0;
      err_q    <= 1'b0;
      rvm_vd_q <= 1'b0;
    end else begin
      if (accept) begin
        op1_q    <= gnt_id ? req_op1_i[2*SCR1_XLEN-1:SCR1_XLEN] : req_op1_i[SCR1_XLEN-1:0];
        op2_q    <= gnt_id ? req_op2_i[2*SCR1_XLEN-1:SCR1_XLEN] : req_op2_i[SCR1_XLEN-1:0];
        cmd_q    <= gnt_id ? req_cmd_i[2*SCR1_IALU_CMD_WIDTH-1:SCR1_IALU_CMD_WIDTH]
                           : req_cmd_i[SCR1_IALU_CMD_WIDTH-1:0];
        rvm_vd_q <= gnt_id ? req_cmd_i[SCR1_IALU_CMD_WIDTH+RVM_CMD_BIT]
                           : req_cmd_i[RVM_CMD_BIT];
        id_q     <= gnt_id;
        last_q   <= gnt_id;
        cnt_q    <= '0;
      end
      if (state_q == EXEC) begin
        if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
        if (exec_done) begin
          rvm_vd_q <= 1'b0;
          res_q    <= exec_ok ? ialu_main_res_i : '0;
          cmp_q    <= exec_ok ? ialu_cmp_res_i  : 1'b0;
          err_q    <= !exec_ok;
        end
      end
    end
  end

  assign ialu_main_op1_o   = op1_q;
  assign ialu_main_op2_o   = op2_q;
  assign ialu_cmd_o        = cmd_q;
  assign ialu_rvm_cmd_vd_o = rvm_vd_q;
  assign rsp_id_o          = id_q;
  assign rsp_res_o         = res_q;
  assign rsp_cmp_o         = cmp_q;
  assign rsp_err_o         = err_q;

endmodule

// File: tb/tb_ialu_req_arb.sv
// Self-checking bench for ialu_req_arb: directed scenarios plus randomized traffic
// checked against a transaction-level model of arbitration, latency and timeout.
module tb_ialu_req_arb;
  localparam int XLEN = 8;
  localparam int CW   = 8;
  localparam int TO   = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      req_vd_i = '0;
  logic [1:0]      req_rdy_o;
  logic [2*XLEN-1:0] req_op1_i = '0, req_op2_i = '0;
  logic [2*CW-1:0] req_cmd_i = '0;
  logic [XLEN-1:0] ialu_main_op1_o, ialu_main_op2_o;
  logic [CW-1:0]   ialu_cmd_o;
  logic            ialu_rvm_cmd_vd_o;
  logic [XLEN-1:0] ialu_main_res_i = '0;
  logic            ialu_cmp_res_i = 1'b0;
  logic            ialu_rvm_res_rdy_i = 1'b0;
  logic            rsp_vd_o;
  logic            rsp_rdy_i = 1'b0;
  logic            rsp_id_o;
  logic [XLEN-1:0] rsp_res_o;
  logic            rsp_cmp_o, rsp_err_o;

  always #5 clk = ~clk;

  ialu_req_arb #(.SCR1_XLEN(XLEN), .SCR1_IALU_CMD_WIDTH(CW), .MDU_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_vd_i(req_vd_i), .req_rdy_o(req_rdy_o),
    .req_op1_i(req_op1_i), .req_op2_i(req_op2_i), .req_cmd_i(req_cmd_i),
    .ialu_main_op1_o(ialu_main_op1_o), .ialu_main_op2_o(ialu_main_op2_o),
    .ialu_cmd_o(ialu_cmd_o), .ialu_rvm_cmd_vd_o(ialu_rvm_cmd_vd_o),
    .ialu_main_res_i(ialu_main_res_i), .ialu_cmp_res_i(ialu_cmp_res_i),
    .ialu_rvm_res_rdy_i(ialu_rvm_res_rdy_i),
    .rsp_vd_o(rsp_vd_o), .rsp_rdy_i(rsp_rdy_i), .rsp_id_o(rsp_id_o),
    .rsp_res_o(rsp_res_o), .rsp_cmp_o(rsp_cmp_o), .rsp_err_o(rsp_err_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester-side model: each requester holds its operation until it is granted.
  bit              pend [2];
  logic [XLEN-1:0] m_op1 [2];
  logic [XLEN-1:0] m_op2 [2];
  logic [CW-1:0]   m_cmd [2];
  bit              last_m = 1'b1;

  function automatic logic [XLEN-1:0] alu_res(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                              input logic [CW-1:0] c);
    return c[CW-1] ? (a ^ b) : (a + b);
  endfunction

  task automatic load(input int r, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [CW-1:0] c);
    pend[r] = 1'b1; m_op1[r] = a; m_op2[r] = b; m_cmd[r] = c;
  endtask

  task automatic drive_reqs();
    req_vd_i  = {pend[1], pend[0]};
    req_op1_i = {m_op1[1], m_op1[0]};
    req_op2_i = {m_op2[1], m_op2[0]};
    req_cmd_i = {m_cmd[1], m_cmd[0]};
    rsp_rdy_i = 1'b0;
    ialu_rvm_res_rdy_i = 1'($urandom_range(0, 1));
    ialu_main_res_i = 8'($urandom);
    ialu_cmp_res_i  = 1'($urandom_range(0, 1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_rdy"}, req_rdy_o, 0);
    check({tag, "_op1"}, ialu_main_op1_o, 0);
    check({tag, "_op2"}, ialu_main_op2_o, 0);
    check({tag, "_cmd"}, ialu_cmd_o, 0);
    check({tag, "_rvm_vd"}, ialu_rvm_cmd_vd_o, 0);
    check({tag, "_rsp"}, {rsp_vd_o, rsp_id_o, rsp_res_o, rsp_cmp_o, rsp_err_o}, 0);
  endtask

  // One full operation: IDLE grant, EXEC (lat = EXEC cycle index of res_rdy), RESP held wt cycles.
  task automatic run_txn(input int lat, input int wt);
    bit g, rvm, eerr, cap, done;
    logic [XLEN-1:0] eo1, eo2, er;
    logic [CW-1:0]   ec;
    logic            ecmp;
    int k, vd_cycles;
    @(negedge clk);
    drive_reqs();
    #1;
    g = (pend[0] && pend[1]) ? ~last_m : pend[1];
    check("grant_rdy", req_rdy_o, g ? 2'b10 : 2'b01);
    check("idle_rsp_vd", rsp_vd_o, 0);
    check("idle_rvm_vd", ialu_rvm_cmd_vd_o, 0);
    eo1 = m_op1[g]; eo2 = m_op2[g]; ec = m_cmd[g];
    rvm = ec[CW-1];
    er = alu_res(eo1, eo2, ec);
    ecmp = (eo1 > eo2);
    last_m = g;
    pend[g] = 1'b0;
    k = 0; done = 1'b0; vd_cycles = 0;
    while (!done) begin
      @(negedge clk);
      drive_reqs();
      cap = !rvm || (k == lat);
      if (rvm) ialu_rvm_res_rdy_i = (k == lat);
      ialu_main_res_i = cap ? er : ~er;
      ialu_cmp_res_i  = cap ? ecmp : ~ecmp;
      #1;
      check("exec_op1", ialu_main_op1_o, eo1);
      check("exec_op2", ialu_main_op2_o, eo2);
      check("exec_cmd", ialu_cmd_o, ec);
      check("exec_rdy", req_rdy_o, 0);
      check("exec_rsp_vd", rsp_vd_o, 0);
      if (ialu_rvm_cmd_vd_o) vd_cycles++;
      done = cap || (k == TO - 1);
      k++;
    end
    check("rvm_vd_cycles", vd_cycles, rvm ? ((lat + 1 < TO) ? lat + 1 : TO) : 0);
    eerr = rvm && (lat > TO - 1);
    if (eerr) begin er = '0; ecmp = 1'b0; end
    for (int w = 0; w <= wt; w++) begin
      @(negedge clk);
      drive_reqs();
      rsp_rdy_i = (w == wt);
      ialu_main_res_i = ~er;
      #1;
      check("rsp_vd", rsp_vd_o, 1);
      check("rsp_id", rsp_id_o, g);
      check("rsp_res", rsp_res_o, er);
      check("rsp_cmp", rsp_cmp_o, ecmp);
      check("rsp_err", rsp_err_o, eerr);
      check("rsp_rdy_blk", req_rdy_o, 0);
      check("rsp_rvm_vd", ialu_rvm_cmd_vd_o, 0);
      check("rsp_op1_hold", ialu_main_op1_o, eo1);
    end
  endtask

  initial begin
    for (int r = 0; r < 2; r++) begin
      pend[r] = 1'b0; m_op1[r] = '0; m_op2[r] = '0; m_cmd[r] = '0;
    end
    // Reset state, including with both requesters asserting.
    #1;
    check_all_zero("reset");
    req_vd_i = 2'b11;
    #1;
    check("reset_gated_rdy", req_rdy_o, 0);
    req_vd_i = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single non-RVM operation with rsp_vd at T+2.
    load(0, 8'h12, 8'h05, 8'h01);
    run_txn(0, 0);

    // Contention: both always requesting -> grants alternate 0,1,0,1.
    load(0, 8'h21, 8'h03, 8'h02);
    load(1, 8'h40, 8'h44, 8'h03);
    for (int i = 0; i < 4; i++) begin
      run_txn(0, 0);
      if (!pend[0]) load(0, 8'($urandom), 8'($urandom), 8'h04);
      if (!pend[1]) load(1, 8'($urandom), 8'($urandom), 8'h05);
    end
    pend[0] = 1'b0; pend[1] = 1'b0;

    // Idle cycle with nothing requested.
    @(negedge clk);
    drive_reqs();
    #1;
    check("idle_none_rdy", req_rdy_o, 0);
    check("idle_none_vd", rsp_vd_o, 0);

    // RVM: res_rdy after 5 cycles, result 0x3C.
    load(1, 8'h30, 8'h0C, 8'h80);
    run_txn(5, 0);
    // Timeout: res_rdy never arrives.
    load(0, 8'h11, 8'h22, 8'h81);
    run_txn(1000, 1);
    // res_rdy on the final allowed cycle wins over the timeout.
    load(1, 8'h5A, 8'hA5, 8'h82);
    run_txn(TO - 1, 0);
    // Backpressure: response held for 10 cycles.
    load(0, 8'h77, 8'h01, 8'h06);
    run_txn(0, 10);

    // Async reset during RVM EXEC.
    load(1, 8'h99, 8'h66, 8'h85);
    @(negedge clk);
    drive_reqs();
    @(negedge clk);
    pend[1] = 1'b0;
    drive_reqs();
    ialu_rvm_res_rdy_i = 1'b0;
    #1;
    check("pre_reset_rvm_vd", ialu_rvm_cmd_vd_o, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    last_m = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all_zero("postreset");
    load(0, 8'h01, 8'h02, 8'h07);
    load(1, 8'h03, 8'h04, 8'h08);
    run_txn(0, 0);
    check("first_grant_after_reset", {31'd0, pend[1]}, 1);
    pend[1] = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      for (int r = 0; r < 2; r++)
        if (!pend[r] && $urandom_range(0, 1) == 1)
          load(r, 8'($urandom), 8'($urandom),
               {($urandom_range(0, 2) == 0), 7'($urandom)});
      if (!pend[0] && !pend[1])
        load(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
             {($urandom_range(0, 2) == 0), 7'($urandom)});
      run_txn(int'($urandom_range(0, 9)), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ialu_req_arb.md
Name: ialu_req_arb

Overview:
- Two-requester arbiter and sequencer for the shared SCR1 IALU main datapath.
- Accepts operations over valid/ready handshakes, selects a requester round-robin, and drives the IALU operands and command.
- Multi-cycle RVM (mul/div) commands are sequenced through the rvm_cmd_vd/res_rdy handshake under a timeout watchdog.
- Returns the registered result, compare flag and requester ID on a single response channel with backpressure.

Parameters:
- SCR1_XLEN, 8, operand/result width.
- SCR1_IALU_CMD_WIDTH, 8, IALU command width.
- RVM_CMD_BIT, SCR1_IALU_CMD_WIDTH-1, command bit index; when set, the command is an RVM (multi-cycle) command.
- MDU_TIMEOUT, 64, maximum cycles spent waiting for ialu_rvm_res_rdy before aborting; range 2..255.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- req_vd_i  in  2  per-requester request valid; bit r belongs to requester r.
- req_rdy_o  out  2  per-requester accept.
- req_op1_i  in  2*SCR1_XLEN  operand 1; requester r uses slice [r*XLEN +: XLEN].
- req_op2_i  in  2*SCR1_XLEN  operand 2, sliced the same way.
- req_cmd_i  in  2*SCR1_IALU_CMD_WIDTH  command, sliced per requester.
- ialu_main_op1_o  out  SCR1_XLEN  operand 1 to the IALU.
- ialu_main_op2_o  out  SCR1_XLEN  operand 2 to the IALU.
- ialu_cmd_o  out  SCR1_IALU_CMD_WIDTH  command to the IALU.
- ialu_rvm_cmd_vd_o  out  1  RVM command valid.
- ialu_main_res_i  in  SCR1_XLEN  IALU result.
- ialu_cmp_res_i  in  1  IALU compare result.
- ialu_rvm_res_rdy_i  in  1  RVM result ready.
- rsp_vd_o  out  1  response valid.
- rsp_rdy_i  in  1  response accept.
- rsp_id_o  out  1  ID of the requester being answered.
- rsp_res_o  out  SCR1_XLEN  result.
- rsp_cmp_o  out  1  compare result.
- rsp_err_o  out  1  set when the RVM operation timed out.

Behaviour:
- Reset values (async, immediate): all outputs 0; FSM IDLE; last-grant pointer = 1, so requester 0 wins first; all holding registers 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE, grant:
  - Grant = requester with req_vd_i set.
  - If both are set, grant the one that is not the last-grant pointer.
  - req_rdy_o[grant] = 1 combinationally in IDLE only; the other bit = 0.
- IDLE, capture: on handshake, latch op1/op2/cmd/ID, update the pointer to grant, go to EXEC. No request: stay.
- IALU drive:
  - ialu_main_op1_o/op2_o/cmd_o come from the holding registers.
  - They are stable in EXEC and RESP and hold their last values in IDLE.
- EXEC, non-RVM command (cmd[RVM_CMD_BIT]=0):
  - ialu_rvm_cmd_vd_o = 0.
  - Capture ialu_main_res_i/ialu_cmp_res_i at the end of the single EXEC cycle; rsp_err = 0; go to RESP.
- EXEC, RVM command:
  - ialu_rvm_cmd_vd_o = 1, registered: high from the first EXEC cycle until the cycle after res_rdy is sampled.
  - Timeout counter clears on EXEC entry and increments each EXEC cycle.
  - On ialu_rvm_res_rdy_i = 1: capture res/cmp, rsp_err = 0, go to RESP.
  - Else, if counter == MDU_TIMEOUT-1: res = 0, cmp = 0, rsp_err = 1, go to RESP, deassert rvm_cmd_vd.
  - res_rdy arriving in the same cycle as the timeout wins: normal completion.
- RESP:
  - rsp_vd_o = 1 with stable id/res/cmp/err until rsp_rdy_i = 1.
  - Then go to IDLE; rsp_vd_o = 0 next cycle.
  - ialu_rvm_res_rdy_i is ignored outside EXEC.
- Latency (non-RVM): accept at cycle T, EXEC at T+1, rsp_vd_o high at T+2. Throughput is one operation per 3 cycles minimum.
- Latency (RVM): rsp_vd_o is high one cycle after the res_rdy cycle.
- Backpressure: req_rdy_o stays 0 while in EXEC/RESP; a requester must hold req_vd_i and its operands.
- Reset mid-operation: everything returns to reset values asynchronously; an in-flight operation is dropped with no response; rvm_cmd_vd falls immediately.
- Width rules: no arithmetic on data; the counter is 8 bits and saturates.

Test Plan:
- Single non-RVM: req0 op1=0x12, op2=0x05, cmd=0x01, IALU model returns 0x17/cmp=1 -> rsp_vd at T+2, id=0, res=0x17, cmp=1, err=0.
- Contention: req_vd_i=2'b11 held for 4 operations -> grants 0,1,0,1; rsp_id sequence 0,1,0,1; each req_rdy is a single-cycle pulse.
- RVM: cmd=0x80, res_rdy after 5 cycles with res=0x3C -> rvm_cmd_vd high for 6 cycles, rsp res=0x3C, err=0.
- Timeout: MDU_TIMEOUT=8, res_rdy never asserted -> exactly 8 EXEC cycles, then rsp_err=1, res=0, rvm_cmd_vd low.
- Backpressure: rsp_rdy_i low for 10 cycles -> rsp fields stable, req_rdy_o=0, then IDLE one cycle after accept.
- Async reset asserted during RVM EXEC -> all outputs 0 without waiting for a clock edge, no response; first grant after reset goes to requester 0.
